regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single synchronous write port between two writeback sources, ALU and MEM.
//  Round-robin arbitration with a valid/ready handshake per source; the winning write is registered one
//  stage and then driven onto the regfile write port.
//  Also keeps a pending-write scoreboard (one busy bit per register) that issue logic uses for RAW/WAW stalls.
// PARAMETERS
//  DATABUS_SIZE       24  write data width; matches the regfile data bus
//  REGFILE_ADDR_BITS  4   register address width
//  REGFILE_NUM_REGS   16  register count, equal to 2**REGFILE_ADDR_BITS
// PORTS
//  clk            in   1    single clock, all state updates on posedge
//  rst_n          in   1    asynchronous active-low reset
//  alu_valid      in   1    ALU writeback request
//  alu_ready      out  1    ALU request granted this cycle (combinational)
//  alu_addr       in   A    ALU destination register (A = REGFILE_ADDR_BITS)
//  alu_data       in   D    ALU result (D = DATABUS_SIZE)
//  mem_valid      in   1    MEM (load) writeback request
//  mem_ready      out  1    MEM request granted this cycle (combinational)
//  mem_addr       in   A    load destination register
//  mem_data       in   D    load data
//  issue_valid    in   1    an instruction with a destination issues this cycle
//  issue_addr     in   A    destination of the issuing instruction
//  busy_vec       out  N    per-register pending-write flags (N = REGFILE_NUM_REGS); bit 0 is always 0
//  rf_write_enable out 1    regfile write enable
//  rf_write_addr  out  A    regfile write address
//  rf_write_data  out  D    regfile write data
// BEHAVIOUR
//  - Reset (async, rst_n=0) clears: rf_write_enable=0, rf_write_addr=0, rf_write_data=0, busy_vec=0.
//    Reset also sets the RR pointer to ALU-first. A write held in the output stage at reset is dropped.
//  - Arbitration is combinational from the valids and the RR pointer:
//    - only one source valid -> that source is granted;
//    - both valid -> grant the source NOT granted last; the pointer updates only on a grant.
//    - ready never asserts without the matching valid. At most one grant per cycle.
//  - Accept = valid && ready in cycle N. Then in cycle N+1: rf_write_enable=1, addr/data = the accepted values.
//    Fixed 1-cycle latency. The output stage drains every cycle, so a grant is never blocked by backpressure.
//  - No accept in cycle N -> rf_write_enable=0 in N+1. Addr/data hold their last value (don't-care).
//  - Requests to addr 0 are accepted (ready asserts, pointer advances) but discarded: rf_write_enable stays 0.
//  - Scoreboard, updated on posedge:
//    - issue_valid && issue_addr!=0 sets busy[issue_addr];
//    - rf_write_enable=1 clears busy[rf_write_addr];
//    - set and clear to the same register in the same cycle -> set wins (new producer).
//    - Issue to an already-busy register leaves it busy. Preventing WAW is the issue stage's job.
//  - A requester must hold valid/addr/data stable until ready. A dropped valid without ready is ignored.
// CONFIGURATION
//  - REGFILE_WB_STATS_EN defined: adds outputs stat_conflicts, stat_alu_wr, stat_mem_wr (16 bits each, saturating):
//    - stat_conflicts increments each cycle both valids are high;
//    - stat_alu_wr / stat_mem_wr increment per accepted non-zero-address write;
//    - all three reset to 0 and stick at 16'hFFFF.
//  - REGFILE_WB_STATS_EN undefined: the ports and counters do not exist; arbitration behaviour is identical.
// STRUCTURE
//  - Package regfile_pkg holds:
//    - localparams DATABUS_SIZE, REGFILE_ADDR_BITS, REGFILE_NUM_REGS;
//    - typedef enum logic {WB_SRC_ALU, WB_SRC_MEM} wb_src_e;
//    - typedef struct {addr, data} wb_req_t.
//  - Sub-module rr_arb2: 2-way round-robin arbiter, inputs req[1:0], outputs gnt[1:0] one-hot, holds its own pointer.
//  - The top holds the output register stage, scoreboard and optional stats.
// TESTING
//  1. ALU only: alu_valid=1, addr=3, data=24'h00ABCD in cycle N -> alu_ready=1 in N;
//     rf_we=1, addr=3, data=00ABCD in N+1; rf_we=0 in N+2.
//  2. Both valid for 4 cycles (ALU r1..r4, MEM r5..r8) after reset -> grants ALU,MEM,ALU,MEM;
//     writes r1,r5,r2,r6 in cycles N+1..N+4.
//  3. issue r7, then MEM writes r7 -> busy_vec[7]=1 from the cycle after issue; it returns to 0 the cycle after rf_we to r7.
//  4. Same cycle: issue r2 plus an output-stage write to r2 -> busy_vec[2] stays 1.
//     Separately: issue r0 -> busy_vec stays 0.
//  5. ALU write to addr 0 -> alu_ready=1, rf_write_enable stays 0; the RR pointer favours MEM next.
//  6. rst_n low mid-stream with a write in the output stage -> outputs and busy_vec are 0 immediately.
//     After release: ALU gets priority on the first conflict, and the dropped write never appears.
//     With REGFILE_WB_STATS_EN: counters read 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the regfile writeback arbiter.
package regfile_pkg;

  localparam int DATABUS_SIZE      = 24;
  localparam int REGFILE_ADDR_BITS = 4;
  localparam int REGFILE_NUM_REGS  = 1 << REGFILE_ADDR_BITS;

  typedef enum logic {WB_SRC_ALU = 1'b0, WB_SRC_MEM = 1'b1} wb_src_e;

  typedef struct packed {
    logic [REGFILE_ADDR_BITS-1:0] addr;
    logic [DATABUS_SIZE-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two requesters, issue port, scoreboard and regfile write port.
interface regfile_wb_if;
  import regfile_pkg::*;

  logic                         alu_valid;
  logic                         alu_ready;
  logic [REGFILE_ADDR_BITS-1:0] alu_addr;
  logic [DATABUS_SIZE-1:0]      alu_data;
  logic                         mem_valid;
  logic                         mem_ready;
  logic [REGFILE_ADDR_BITS-1:0] mem_addr;
  logic [DATABUS_SIZE-1:0]      mem_data;
  logic                         issue_valid;
  logic [REGFILE_ADDR_BITS-1:0] issue_addr;
  logic [REGFILE_NUM_REGS-1:0]  busy_vec;
  logic                         rf_write_enable;
  logic [REGFILE_ADDR_BITS-1:0] rf_write_addr;
  logic [DATABUS_SIZE-1:0]      rf_write_data;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  issue_valid, issue_addr,
    output alu_ready, mem_ready, busy_vec,
    output rf_write_enable, rf_write_addr, rf_write_data
  );

  // Requester / pipeline side
  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output issue_valid, issue_addr,
    input  alu_ready, mem_ready, busy_vec,
    input  rf_write_enable, rf_write_addr, rf_write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. req/gnt bit 0 = ALU, bit 1 = MEM.
// On a conflict the source not granted last wins; the pointer moves on any grant.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  wb_src_e prio_q, prio_d;

  // Grant selection and next priority
  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (prio_q == WB_SRC_ALU) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (gnt_o[0])      prio_d = WB_SRC_MEM;
    else if (gnt_o[1]) prio_d = WB_SRC_ALU;
  end

  // Priority pointer, ALU-first out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= WB_SRC_ALU;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter: RR grant between ALU and MEM, one register
// stage to the regfile write port, and a pending-write scoreboard.
// Optional saturating statistics counters when REGFILE_WB_STATS_EN is defined.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  regfile_wb_if.slave wb
`ifdef REGFILE_WB_STATS_EN
  ,
  output logic [15:0] stat_conflicts,
  output logic [15:0] stat_alu_wr,
  output logic [15:0] stat_mem_wr
`endif
);

  logic [1:0]                  gnt;
  wb_req_t                     sel_req;
  logic                        wr_ok;
  logic                        we_q;
  wb_req_t                     out_q;
  logic [REGFILE_NUM_REGS-1:0] busy_q, busy_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({wb.mem_valid, wb.alu_valid}),
    .gnt_o (gnt)
  );

  assign wb.alu_ready = gnt[0];
  assign wb.mem_ready = gnt[1];

  // Mux the winning request; writes to r0 are accepted but never reach the port
  always_comb begin
    sel_req = gnt[1] ? wb_req_t'{addr: wb.mem_addr, data: wb.mem_data}
                     : wb_req_t'{addr: wb.alu_addr, data: wb.alu_data};
    wr_ok   = (|gnt) && (sel_req.addr != '0);
  end

  // Output stage: drains every cycle, addr/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      out_q <= '0;
    end else begin
      we_q <= wr_ok;
      if (wr_ok) out_q <= sel_req;
    end
  end

  // Scoreboard next state: clear on write, then set on issue so a new producer wins
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[out_q.addr] = 1'b0;
    if (wb.issue_valid && (wb.issue_addr != '0)) busy_d[wb.issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign wb.busy_vec        = busy_q;
  assign wb.rf_write_enable = we_q;
  assign wb.rf_write_addr   = out_q.addr;
  assign wb.rf_write_data   = out_q.data;

`ifdef REGFILE_WB_STATS_EN
  logic [15:0] conf_q, alu_q, mem_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_q <= '0;
      alu_q  <= '0;
      mem_q  <= '0;
    end else begin
      if (wb.alu_valid && wb.mem_valid && conf_q != 16'hFFFF) conf_q <= conf_q + 16'd1;
      if (wr_ok && gnt[0] && alu_q != 16'hFFFF)               alu_q  <= alu_q + 16'd1;
      if (wr_ok && gnt[1] && mem_q != 16'hFFFF)               mem_q  <= mem_q + 16'd1;
    end
  end

  assign stat_conflicts = conf_q;
  assign stat_alu_wr    = alu_q;
  assign stat_mem_wr    = mem_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Inputs change on negedge or 1ns
// after posedge; registered outputs are sampled 1ns after posedge.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  regfile_wb_if bus ();

`ifdef REGFILE_WB_STATS_EN
  logic [15:0] stat_conflicts, stat_alu_wr, stat_mem_wr;
`endif

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus.slave)
`ifdef REGFILE_WB_STATS_EN
    ,
    .stat_conflicts (stat_conflicts),
    .stat_alu_wr    (stat_alu_wr),
    .stat_mem_wr    (stat_mem_wr)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_addr = '0; bus.mem_data = '0;
    bus.issue_addr = '0;
    #1;
    n_vec++; if (bus.rf_write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", bus.rf_write_enable); end
    n_vec++; if (bus.rf_write_addr !== 4'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.rf_write_addr); end
    n_vec++; if (bus.rf_write_data !== 24'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.rf_write_data); end
    n_vec++; if (bus.busy_vec !== 16'h0) begin n_err++; $display("FAIL reset_busy: got %h want 0", bus.busy_vec); end
    n_vec++; if ({bus.mem_ready, bus.alu_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {bus.mem_ready, bus.alu_ready}); end
`ifdef REGFILE_WB_STATS_EN
    n_vec++; if ({stat_conflicts, stat_alu_wr, stat_mem_wr} !== 48'h0) begin n_err++; $display("FAIL reset_stats: got %h want 0", {stat_conflicts, stat_alu_wr, stat_mem_wr}); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_only();
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 24'h00ABCD;
    #1;
    n_vec++; if ({bus.mem_ready, bus.alu_ready} !== 2'b01) begin n_err++; $display("FAIL alu_only_ready: got %b want 01", {bus.mem_ready, bus.alu_ready}); end
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
    n_vec++; if ({bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data} !== {1'b1, 4'd3, 24'h00ABCD})
      begin n_err++; $display("FAIL alu_only_write: got we=%b a=%h d=%h want we=1 a=3 d=00abcd", bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data); end
    @(posedge clk); #1;
    n_vec++; if (bus.rf_write_enable !== 1'b0) begin n_err++; $display("FAIL alu_only_idle: got we=%b want 0", bus.rf_write_enable); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [3:0]  exp_a [4] = '{4'd1, 4'd5, 4'd2, 4'd6};
    logic [23:0] exp_d [4] = '{24'hA5A501, 24'hA5A505, 24'hA5A502, 24'hA5A506};
    int ai = 0;
    int mi = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.alu_valid = 1'b1; bus.alu_addr = 4'(1 + ai); bus.alu_data = 24'(24'hA5A501 + ai);
      bus.mem_valid = 1'b1; bus.mem_addr = 4'(5 + mi); bus.mem_data = 24'(24'hA5A505 + mi);
      #1;
      n_vec++; if ({bus.mem_ready, bus.alu_ready} !== exp_g[c]) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", c, {bus.mem_ready, bus.alu_ready}, exp_g[c]); end
      if (bus.alu_ready) ai++;
      else if (bus.mem_ready) mi++;
      @(posedge clk); #1;
      n_vec++; if ({bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data} !== {1'b1, exp_a[c], exp_d[c]})
        begin n_err++; $display("FAIL rr_write[%0d]: got we=%b a=%h d=%h want we=1 a=%h d=%h", c, bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data, exp_a[c], exp_d[c]); end
    end
    idle();
`ifdef REGFILE_WB_STATS_EN
    n_vec++; if ({stat_conflicts, stat_alu_wr, stat_mem_wr} !== {16'd4, 16'd2, 16'd2}) begin n_err++; $display("FAIL rr_stats: got %0d/%0d/%0d want 4/2/2", stat_conflicts, stat_alu_wr, stat_mem_wr); end
`endif
    @(posedge clk); #1;
    n_vec++; if (bus.rf_write_enable !== 1'b0) begin n_err++; $display("FAIL rr_drain: got we=%b want 0", bus.rf_write_enable); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_addr = 4'd7;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    n_vec++; if (bus.busy_vec !== 16'h0080) begin n_err++; $display("FAIL sb_set: got %h want 0080", bus.busy_vec); end
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd7; bus.mem_data = 24'h123456;
    #1;
    n_vec++; if ({bus.mem_ready, bus.alu_ready} !== 2'b10) begin n_err++; $display("FAIL sb_mem_ready: got %b want 10", {bus.mem_ready, bus.alu_ready}); end
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    n_vec++; if ({bus.rf_write_enable, bus.rf_write_addr} !== {1'b1, 4'd7}) begin n_err++; $display("FAIL sb_write: got we=%b a=%h want we=1 a=7", bus.rf_write_enable, bus.rf_write_addr); end
    n_vec++; if (bus.busy_vec !== 16'h0080) begin n_err++; $display("FAIL sb_still_busy: got %h want 0080", bus.busy_vec); end
    @(posedge clk); #1;
    n_vec++; if (bus.busy_vec !== 16'h0000) begin n_err++; $display("FAIL sb_clear: got %h want 0000", bus.busy_vec); end
  endtask

  task automatic test_set_wins();
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd2; bus.alu_data = 24'h000222;
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
    n_vec++; if ({bus.rf_write_enable, bus.rf_write_addr} !== {1'b1, 4'd2}) begin n_err++; $display("FAIL sw_write: got we=%b a=%h want we=1 a=2", bus.rf_write_enable, bus.rf_write_addr); end
    bus.issue_valid = 1'b1; bus.issue_addr = 4'd2;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    n_vec++; if (bus.busy_vec !== 16'h0004) begin n_err++; $display("FAIL sw_set_wins: got %h want 0004", bus.busy_vec); end
    @(posedge clk); #1;
    n_vec++; if (bus.busy_vec !== 16'h0004) begin n_err++; $display("FAIL sw_hold: got %h want 0004", bus.busy_vec); end
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_addr = 4'd0;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    n_vec++; if (bus.busy_vec !== 16'h0004) begin n_err++; $display("FAIL sw_issue_r0: got %h want 0004", bus.busy_vec); end
  endtask

  task automatic test_addr0();
    do_reset();
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd0; bus.alu_data = 24'hFFFFFF;
    #1;
    n_vec++; if ({bus.mem_ready, bus.alu_ready} !== 2'b01) begin n_err++; $display("FAIL a0_ready: got %b want 01", {bus.mem_ready, bus.alu_ready}); end
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
    n_vec++; if (bus.rf_write_enable !== 1'b0) begin n_err++; $display("FAIL a0_no_write: got we=%b want 0", bus.rf_write_enable); end
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd1; bus.alu_data = 24'h000111;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd9; bus.mem_data = 24'h000999;
    #1;
    n_vec++; if ({bus.mem_ready, bus.alu_ready} !== 2'b10) begin n_err++; $display("FAIL a0_ptr_mem: got %b want 10", {bus.mem_ready, bus.alu_ready}); end
    @(posedge clk); #1;
    idle();
    n_vec++; if ({bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data} !== {1'b1, 4'd9, 24'h000999})
      begin n_err++; $display("FAIL a0_mem_write: got we=%b a=%h d=%h want we=1 a=9 d=000999", bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data); end
`ifdef REGFILE_WB_STATS_EN
    n_vec++; if ({stat_conflicts, stat_alu_wr, stat_mem_wr} !== {16'd1, 16'd0, 16'd1}) begin n_err++; $display("FAIL a0_stats: got %0d/%0d/%0d want 1/0/1", stat_conflicts, stat_alu_wr, stat_mem_wr); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd4; bus.alu_data = 24'h444444;
    bus.issue_valid = 1'b1; bus.issue_addr = 4'd5;
    @(posedge clk); #1;
    idle();
    n_vec++; if ({bus.rf_write_enable, bus.busy_vec} !== {1'b1, 16'h0020}) begin n_err++; $display("FAIL rm_pre: got we=%b busy=%h want we=1 busy=0020", bus.rf_write_enable, bus.busy_vec); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data} !== 29'h0) begin n_err++; $display("FAIL rm_out_clear: got we=%b a=%h d=%h want 0", bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data); end
    n_vec++; if (bus.busy_vec !== 16'h0) begin n_err++; $display("FAIL rm_busy_clear: got %h want 0", bus.busy_vec); end
`ifdef REGFILE_WB_STATS_EN
    n_vec++; if ({stat_conflicts, stat_alu_wr, stat_mem_wr} !== 48'h0) begin n_err++; $display("FAIL rm_stats: got %h want 0", {stat_conflicts, stat_alu_wr, stat_mem_wr}); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus.rf_write_enable !== 1'b0) begin n_err++; $display("FAIL rm_dropped: got we=%b want 0", bus.rf_write_enable); end
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd6; bus.alu_data = 24'h000666;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd8; bus.mem_data = 24'h000888;
    #1;
    n_vec++; if ({bus.mem_ready, bus.alu_ready} !== 2'b01) begin n_err++; $display("FAIL rm_alu_first: got %b want 01", {bus.mem_ready, bus.alu_ready}); end
    @(posedge clk); #1;
    idle();
    n_vec++; if ({bus.rf_write_enable, bus.rf_write_addr} !== {1'b1, 4'd6}) begin n_err++; $display("FAIL rm_write: got we=%b a=%h want we=1 a=6", bus.rf_write_enable, bus.rf_write_addr); end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_round_robin();
    test_scoreboard();
    test_set_wins();
    test_addr0();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
